conv_out_scheduler: RTL and testbench

CONV_OUT_SCHEDULER -- requirements
Module: conv_out_scheduler

---
 rtl/conv_out_scheduler.sv | 157 +++++++++++++++
 tb/tb_conv_out_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_scheduler.sv
// Layer scheduler for the ConvOutput datapath: gates the activation stream, counts beats, flags the last output beat.
// Build option: define CONV_SCHED_AUTO_RESTART_EN to rerun the latched layer after each DONE instead of returning to IDLE.
module conv_out_scheduler #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [11:0]       cfg_in_channel,
    input  logic [9:0]        cfg_rows,
    input  logic [9:0]        cfg_cols,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [DATA_W-1:0] d_data,
    output logic              d_start,
    input  logic              o_valid,
    input  logic              o_ready,
    output logic              o_last,
    output logic              busy,
    output logic              done,
    output logic              err_cfg
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [11:0]      cfg_ch_q;
    logic [9:0]       cfg_rows_q;
    logic [9:0]       cfg_cols_q;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] in_next;
    logic [CNT_W-1:0] out_next;
    logic [9:0]       ch_groups;
    logic [28:0]      total_calc;
    logic             cfg_ok;
    logic             in_run;
    logic             s_hs;
    logic             o_hs;
    logic             out_sat;

    assign cfg_ok = (cfg_in_channel != 12'd0) && (cfg_rows != 10'd0) && (cfg_cols != 10'd0);

    // Eight channels per word, so the channel count rounds up to whole words.
    assign ch_groups  = 10'((13'(cfg_ch_q) + 13'd7) >> 3);
    assign total_calc = 29'(cfg_rows_q) * 29'(cfg_cols_q) * 29'(ch_groups);

    assign in_run  = (state == ST_RUN);
    assign s_ready = in_run && d_ready;
    assign d_valid = in_run && s_valid;
    assign d_data  = s_data;

    assign s_hs     = s_valid && s_ready;
    assign o_hs     = o_valid && o_ready;
    assign out_sat  = (out_cnt == total);
    assign in_next  = in_cnt + CNT_W'(s_hs);
    assign out_next = (o_hs && !out_sat) ? out_cnt + CNT_W'(1) : out_cnt;

    assign o_last = o_valid && busy && (out_cnt == total - CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments only, so every branch sees
    // the pre-edge values of state and counters regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            total   <= '0;
            d_start <= 1'b0;
            done    <= 1'b0;
            err_cfg <= 1'b0;
            busy    <= 1'b0;
        end else begin
            d_start <= 1'b0;
            done    <= 1'b0;
            err_cfg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state   <= ST_CFG;
                            busy    <= 1'b1;
                            d_start <= 1'b1;
                            in_cnt  <= '0;
                            out_cnt <= '0;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                ST_CFG: begin
                    total   <= CNT_W'(total_calc);
                    in_cnt  <= '0;
                    out_cnt <= CNT_W'(o_hs);
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    in_cnt  <= in_next;
                    out_cnt <= out_next;
                    if (s_hs && (in_next == total)) begin
                        // Outputs may already be complete when the last input lands.
                        if (out_next == total) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    out_cnt <= out_next;
                    if (out_next == total) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
`ifdef CONV_SCHED_AUTO_RESTART_EN
                    state   <= ST_CFG;
                    d_start <= 1'b1;
                    in_cnt  <= '0;
                    out_cnt <= '0;
`else
                    state <= ST_IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the layer config is plain data qualified by state, so it carries no reset;
    // it is only read after an accepted start has loaded it.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && start && cfg_ok) begin
            cfg_ch_q   <= cfg_in_channel;
            cfg_rows_q <= cfg_rows;
            cfg_cols_q <= cfg_cols;
        end
    end

endmodule

// File: tb/tb_conv_out_scheduler.sv
// Directed bench for conv_out_scheduler: a vector table of layer configs plus abort and auto-restart sequences.
`timescale 1ns/1ps
module tb_conv_out_scheduler;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [11:0]       cfg_in_channel;
    logic [9:0]        cfg_rows;
    logic [9:0]        cfg_cols;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              d_valid;
    logic              d_ready;
    logic [DATA_W-1:0] d_data;
    logic              d_start;
    logic              o_valid;
    logic              o_ready;
    logic              o_last;
    logic              busy;
    logic              done;
    logic              err_cfg;

    always #5 clk = ~clk;

    conv_out_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_in_channel (cfg_in_channel),
        .cfg_rows       (cfg_rows),
        .cfg_cols       (cfg_cols),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .d_data         (d_data),
        .d_start        (d_start),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_last         (o_last),
        .busy           (busy),
        .done           (done),
        .err_cfg        (err_cfg)
    );

    typedef struct {
        logic [11:0] ch;
        logic [9:0]  rows;
        logic [9:0]  cols;
        bit          toggle_ready;
        bit          zero_lat;
        bit          poke_start;
        int          exp_beats;
        bit          exp_err;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] word(input int k);
        logic [31:0] u;
        u = 32'(k);
        return {u ^ 32'hA5C3_0F17, u};
    endfunction

    // One layer: start pulse, stream source, datapath model with 0 or 1 cycle output latency.
    task automatic run_layer(input vec_t v, input string tag);
        int cyc, beats, out_beats, ds_cnt, err_cnt, done_cnt, olast_cnt, data_err, busy_seen;
        int olast_beat, olast_cyc, done_cyc, last_in_cyc, s_ready_after, busy_after, budget;
        bit pend, hs, finished;
        beats = 0; out_beats = 0; ds_cnt = 0; err_cnt = 0; done_cnt = 0;
        olast_cnt = 0; data_err = 0; busy_seen = 0;
        olast_beat = -1; olast_cyc = -10; done_cyc = -1; last_in_cyc = -1;
        s_ready_after = -1; busy_after = -1;
        pend = 1'b0; hs = 1'b0; finished = 1'b0;
        budget = v.exp_err ? 6 : 4 * v.exp_beats + 40;
        cfg_in_channel = v.ch;
        cfg_cols       = v.cols;
        for (cyc = 0; cyc < budget && !finished; cyc++) begin
            start    = (cyc == 0) || (v.poke_start && cyc == 5);
            cfg_rows = (v.poke_start && cyc == 5) ? 10'd0 : v.rows;
            s_valid  = 1'b1;
            s_data   = word(beats);
            d_ready  = v.toggle_ready ? cyc[0] : 1'b1;
            o_ready  = 1'b1;
            o_valid  = v.zero_lat ? 1'b0 : pend;
            #1;
            if (v.zero_lat) o_valid = d_valid && d_ready;
            @(negedge clk);
            if (d_start) ds_cnt++;
            if (err_cfg) err_cnt++;
            if (busy) busy_seen = 1;
            hs = d_valid && d_ready;
            if (hs) begin
                if (d_data !== word(beats)) data_err++;
                beats++;
                if (beats == v.exp_beats) last_in_cyc = cyc;
            end
            if (last_in_cyc >= 0 && cyc == last_in_cyc + 1) s_ready_after = int'(s_ready || d_valid);
            if (o_valid && o_ready) begin
                out_beats++;
                if (o_last) begin
                    olast_cnt++;
                    olast_beat = out_beats;
                    olast_cyc  = cyc;
                end
            end else if (o_last) begin
                olast_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = int'(busy);
                finished   = 1'b1;
            end
            pend = hs;
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        o_valid  = 1'b0;
        cfg_rows = v.rows;
        if (v.exp_err) begin
            check({tag, "_err_cfg_pulses"}, err_cnt, 1);
            check({tag, "_d_start_pulses"}, ds_cnt, 0);
            check({tag, "_busy_seen"}, busy_seen, 0);
            check({tag, "_beats"}, beats, 0);
        end else begin
            check({tag, "_d_start_pulses"}, ds_cnt, 1);
            check({tag, "_err_cfg_pulses"}, err_cnt, 0);
            check({tag, "_in_beats"}, beats, v.exp_beats);
            check({tag, "_out_beats"}, out_beats, v.exp_beats);
            check({tag, "_data_order_errs"}, data_err, 0);
            check({tag, "_o_last_count"}, olast_cnt, 1);
            check({tag, "_o_last_beat"}, olast_beat, v.exp_beats);
            check({tag, "_done_pulses"}, done_cnt, 1);
            check({tag, "_done_after_last"}, done_cyc - olast_cyc, 1);
            check({tag, "_s_ready_after_last_in"}, s_ready_after, 0);
            check({tag, "_busy_after_done"}, busy_after, 0);
        end
    endtask

    vec_t vecs[10];
    int   beats;
    int   ds;
    int   lb;
    int   last_done;
    int   busy_drop;
    bit   pend;
    bit   hs;

    initial begin
        vecs[0] = '{12'd32,   10'd14, 10'd14, 1'b0, 1'b0, 1'b0, 784, 1'b0};
        vecs[1] = '{12'd12,   10'd2,  10'd3,  1'b0, 1'b0, 1'b1, 12,  1'b0};
        vecs[2] = '{12'd8,    10'd4,  10'd4,  1'b1, 1'b0, 1'b0, 16,  1'b0};
        vecs[3] = '{12'd1,    10'd1,  10'd1,  1'b0, 1'b0, 1'b0, 1,   1'b0};
        vecs[4] = '{12'd9,    10'd1,  10'd2,  1'b0, 1'b1, 1'b0, 4,   1'b0};
        vecs[5] = '{12'd16,   10'd3,  10'd5,  1'b1, 1'b1, 1'b0, 30,  1'b0};
        vecs[6] = '{12'd32,   10'd0,  10'd14, 1'b0, 1'b0, 1'b0, 0,   1'b1};
        vecs[7] = '{12'd0,    10'd3,  10'd3,  1'b0, 1'b0, 1'b0, 0,   1'b1};
        vecs[8] = '{12'd8,    10'd4,  10'd0,  1'b0, 1'b0, 1'b0, 0,   1'b1};
        vecs[9] = '{12'd4095, 10'd1,  10'd1,  1'b0, 1'b0, 1'b0, 512, 1'b0};

        rst = 1'b1; start = 1'b0;
        cfg_in_channel = '0; cfg_rows = '0; cfg_cols = '0;
        s_valid = 1'b1; s_data = '0; d_ready = 1'b1; o_valid = 1'b1; o_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_d_start", d_start, 0);
        check("reset_err_cfg", err_cfg, 0);
        check("reset_s_ready", s_ready, 0);
        check("reset_d_valid", d_valid, 0);
        check("reset_o_last", o_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        o_valid = 1'b0;
        @(posedge clk);
        #1;

`ifdef CONV_SCHED_AUTO_RESTART_EN
        cfg_in_channel = 12'd8; cfg_rows = 10'd2; cfg_cols = 10'd2;
        pend = 1'b0; ds = 0; lb = 0; last_done = -100; busy_drop = 0;
        for (int c = 0; c < 200 && ds < 4; c++) begin
            start = (c == 0); s_valid = 1'b1; d_ready = 1'b1; o_valid = pend;
            @(negedge clk);
            if (c > 1 && !busy) busy_drop++;
            hs = d_valid && d_ready;
            if (d_start) begin
                if (ds > 0) begin
                    check("ar_d_start_after_done", c - last_done, 1);
                    check("ar_layer_beats", lb, 4);
                end
                ds++;
                lb = 0;
            end
            if (hs) lb++;
            if (done) last_done = c;
            pend = hs;
            @(posedge clk);
            #1;
        end
        start = 1'b0; o_valid = 1'b0;
        check("ar_d_start_count", ds, 4);
        check("ar_busy_stayed_high", busy_drop, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ar_reset_busy", busy, 0);
        check("ar_reset_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
`else
        for (int i = 0; i < 10; i++) run_layer(vecs[i], $sformatf("vec%0d", i));

        // Abort a 784-beat layer after beat 100, then rerun it in full.
        cfg_in_channel = 12'd32; cfg_rows = 10'd14; cfg_cols = 10'd14;
        beats = 0;
        for (int c = 0; c < 400 && beats < 100; c++) begin
            start = (c == 0); s_valid = 1'b1; d_ready = 1'b1; o_valid = 1'b0;
            @(negedge clk);
            if (d_valid && d_ready) beats++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("abort_reach_beat100", beats, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_s_ready", s_ready, 0);
        check("abort_d_valid", d_valid, 0);
        check("abort_done", done, 0);
        @(posedge clk);
        #1;
        run_layer(vecs[0], "rerun784");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
